// File: rtl/spi_accel_pkg.sv
// Shared definitions for the SPI accelerometer responder: command bytes, register map, FSM states.
package spi_accel_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    localparam logic [5:0] ADDR_DEVID_AD   = 6'h00;
    localparam logic [5:0] ADDR_DEVID_MST  = 6'h01;
    localparam logic [5:0] ADDR_PARTID     = 6'h02;
    localparam logic [5:0] ADDR_XDATA8     = 6'h08;
    localparam logic [5:0] ADDR_YDATA8     = 6'h09;
    localparam logic [5:0] ADDR_ZDATA8     = 6'h0A;
    localparam logic [5:0] ADDR_XDATA_L    = 6'h0E;
    localparam logic [5:0] ADDR_XDATA_H    = 6'h0F;
    localparam logic [5:0] ADDR_YDATA_L    = 6'h10;
    localparam logic [5:0] ADDR_YDATA_H    = 6'h11;
    localparam logic [5:0] ADDR_ZDATA_L    = 6'h12;
    localparam logic [5:0] ADDR_ZDATA_H    = 6'h13;
    localparam logic [5:0] ADDR_SOFT_RESET = 6'h1F;
    localparam logic [5:0] ADDR_RAM_FIRST  = 6'h20;
    localparam logic [5:0] ADDR_RAM_LAST   = 6'h2E;

    localparam int RAM_FIRST = 32;
    localparam int RAM_LAST  = 46;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD_DATA,
        WR_DATA,
        IGNORE
    } state_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] z;
    } sample_t;

    // 0x1F is the soft-reset key register; it accepts writes but stores nothing.
    function automatic logic is_writable(input logic [5:0] a);
        return (a >= ADDR_SOFT_RESET) && (a <= ADDR_RAM_LAST);
    endfunction

    function automatic logic [7:0] data_hi(input logic [11:0] s);
        return {{4{s[11]}}, s[11:8]};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes one async input into the clock domain and flags its rising/falling edges.
// Latency: edge flags assert STAGES clocks after the input changes.
// Backpressure: none; edges are single-cycle pulses that are never held.
module spi_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave emulating an ADXL362-style accelerometer register file.
// Latency: SPI edges act SYNC_STAGES+1 clocks after they occur; miso follows sclk falls.
// Backpressure: none; the SPI master paces everything, SCLK must stay at or below clock/8.
module spi_accel_responder
    import spi_accel_pkg::*;
#(
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PARTID      = 8'hF2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss,
    output logic        miso,
    input  logic [11:0] accel_x_in,
    input  logic [11:0] accel_y_in,
    input  logic [11:0] accel_z_in,
    output logic        busy,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        cmd_error
);

    logic sclk_rise, sclk_fall;
    logic ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_shift;
    logic [5:0]  addr;
    logic        is_write;
    logic        miso_q;
    logic        soft_clr;
    sample_t     shadow;
    logic [7:0]  ram [RAM_FIRST:RAM_LAST];
    logic [5:0]  rd_addr;
    logic [7:0]  rd_data;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clock (clock),
        .reset (reset),
        .din   (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // ss resets to "selected" so a master already holding ss low at reset release
    // produces no falling edge; only a fresh high-to-low transition starts a transaction.
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ss_sync (
        .clock (clock),
        .reset (reset),
        .din   (ss),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s  = mosi_chain[SYNC_STAGES-1];
    assign rx_byte = {rx_shift, mosi_s};
    // While the address byte completes, the read target is the byte just received.
    assign rd_addr = (state == ADDR) ? rx_byte[5:0] : addr;

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_DEVID_AD:  rd_data = DEVID_AD;
            ADDR_DEVID_MST: rd_data = DEVID_MST;
            ADDR_PARTID:    rd_data = PARTID;
            ADDR_XDATA8:    rd_data = shadow.x[11:4];
            ADDR_YDATA8:    rd_data = shadow.y[11:4];
            ADDR_ZDATA8:    rd_data = shadow.z[11:4];
            ADDR_XDATA_L:   rd_data = shadow.x[7:0];
            ADDR_XDATA_H:   rd_data = data_hi(shadow.x);
            ADDR_YDATA_L:   rd_data = shadow.y[7:0];
            ADDR_YDATA_H:   rd_data = data_hi(shadow.y);
            ADDR_ZDATA_L:   rd_data = shadow.z[7:0];
            ADDR_ZDATA_H:   rd_data = data_hi(shadow.z);
            default: begin
                if (rd_addr >= ADDR_RAM_FIRST && rd_addr <= ADDR_RAM_LAST) begin
                    rd_data = ram[rd_addr];
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            miso_q    <= 1'b0;
            bit_cnt   <= 3'd0;
            rx_shift  <= 7'd0;
            tx_shift  <= 8'h00;
            addr      <= 6'd0;
            is_write  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 6'd0;
            wr_data   <= 8'h00;
            cmd_error <= 1'b0;
            soft_clr  <= 1'b0;
            shadow    <= '0;
            for (int i = RAM_FIRST; i <= RAM_LAST; i++) begin
                ram[6'(i)] <= 8'h00;
            end
        end else begin
            wr_strobe <= 1'b0;
            soft_clr  <= 1'b0;
            if (soft_clr) begin
                for (int i = RAM_FIRST; i <= RAM_LAST; i++) begin
                    ram[6'(i)] <= 8'h00;
                end
            end

            // ss edges take priority over any sclk edge detected in the same cycle.
            if (ss_rise) begin
                state   <= IDLE;
                busy    <= 1'b0;
                miso_q  <= 1'b0;
                bit_cnt <= 3'd0;
            end else if (ss_fall) begin
                state   <= CMD;
                busy    <= 1'b1;
                miso_q  <= 1'b0;
                bit_cnt <= 3'd0;
                shadow  <= {accel_x_in, accel_y_in, accel_z_in};
            end else if (state != IDLE) begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            CMD: begin
                                if (rx_byte == CMD_READ) begin
                                    is_write <= 1'b0;
                                    state    <= ADDR;
                                end else if (rx_byte == CMD_WRITE) begin
                                    is_write <= 1'b1;
                                    state    <= ADDR;
                                end else begin
                                    cmd_error <= 1'b1;
                                    state     <= IGNORE;
                                end
                            end
                            ADDR: begin
                                if (is_write) begin
                                    addr  <= rx_byte[5:0];
                                    state <= WR_DATA;
                                end else begin
                                    tx_shift <= rd_data;
                                    addr     <= rx_byte[5:0] + 6'd1;
                                    state    <= RD_DATA;
                                end
                            end
                            RD_DATA: begin
                                tx_shift <= rd_data;
                                addr     <= addr + 6'd1;
                            end
                            WR_DATA: begin
                                if (is_writable(addr)) begin
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= addr;
                                    wr_data   <= rx_byte;
                                    if (addr == ADDR_SOFT_RESET) begin
                                        soft_clr <= (rx_byte == SOFT_RESET_KEY);
                                    end else begin
                                        ram[addr] <= rx_byte;
                                    end
                                end
                                addr <= addr + 6'd1;
                            end
                            default: ;
                        endcase
                    end
                end else if (sclk_fall && state == RD_DATA) begin
                    miso_q   <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    // Blank miso in the cycle synced ss rises, before the FSM has returned to IDLE.
    assign miso = miso_q & ~ss_rise;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Randomized bench: an SPI master drives transactions, a register-map model predicts miso bytes
// and write strobes, and two monitors pop and compare against what the DUT presents.
module tb_spi_accel_responder;

    localparam int HALF = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sclk  = 1'b0;
    logic        mosi  = 1'b0;
    logic        ss    = 1'b1;
    logic        miso, busy, wr_strobe, cmd_error;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [11:0] ax = 12'h000, ay = 12'h000, az = 12'h000;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_q [$];
    logic [13:0] exp_wr_q [$];
    logic [7:0]  mem [0:63];
    logic [7:0]  wbuf [0:7];
    logic [11:0] snap_x, snap_y, snap_z;

    always #5 clock = ~clock;

    spi_accel_responder dut (
        .clock      (clock),
        .reset      (reset),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss         (ss),
        .miso       (miso),
        .accel_x_in (ax),
        .accel_y_in (ay),
        .accel_z_in (az),
        .busy       (busy),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cmd_error  (cmd_error)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Register map as seen by the master, from the snapshot taken at ss fall.
    function automatic logic [7:0] model_read(input int a);
        int s [3];
        int v;
        s[0] = int'($signed(snap_x));
        s[1] = int'($signed(snap_y));
        s[2] = int'($signed(snap_z));
        case (a)
            0:  return 8'hAD;
            1:  return 8'h1D;
            2:  return 8'hF2;
            8, 9, 10: return 8'((s[a-8] >>> 4) & 255);
            14, 15, 16, 17, 18, 19: begin
                v = s[(a - 14) / 2];
                if ((a % 2) == 0) return 8'(v & 255);
                return 8'((v >>> 8) & 255);
            end
            default: return (a >= 32 && a <= 46) ? mem[a] : 8'h00;
        endcase
    endfunction

    function automatic void model_write(input int a, input logic [7:0] d);
        if (a >= 31 && a <= 46) begin
            exp_wr_q.push_back({6'(a), d});
            if (a == 31) begin
                if (d == 8'h52) for (int k = 32; k <= 46; k++) mem[k] = 8'h00;
            end else begin
                mem[a] = d;
            end
        end
    endfunction

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            repeat (HALF) @(negedge clock);
            sclk = 1'b1;
            repeat (HALF) @(negedge clock);
            sclk = 1'b0;
        end
        if (nbits == 8) check("busy_mid_txn", 32'(busy), 32'd1);
    endtask

    task automatic begin_txn();
        @(negedge clock);
        ss = 1'b0;
        snap_x = ax;
        snap_y = ay;
        snap_z = az;
    endtask

    task automatic end_txn();
        repeat (HALF) @(negedge clock);
        ss = 1'b1;
        repeat (3) @(negedge clock);
        check("busy_after_ss_high", 32'(busy), 32'd0);
        check("miso_idle", 32'(miso), 32'd0);
        repeat (4) @(negedge clock);
    endtask

    // chg_idx >= 0 changes accel_x_in just before that data byte is clocked.
    task automatic do_read(input logic [5:0] a, input int n, input int chg_idx, input logic [11:0] chg_x);
        begin_txn();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        for (int i = 0; i < n; i++) exp_q.push_back(model_read((int'(a) + i) % 64));
        send_bits(8'h0B, 8);
        send_bits({2'($urandom), a}, 8);
        for (int i = 0; i < n; i++) begin
            if (i == chg_idx) ax = chg_x;
            send_bits(8'($urandom), 8);
        end
        end_txn();
    endtask

    task automatic do_write(input logic [5:0] a, input int n);
        int cur;
        cur = int'(a);
        begin_txn();
        for (int i = 0; i < n + 2; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            model_write(cur, wbuf[i]);
            cur = (cur + 1) % 64;
        end
        send_bits(8'h0A, 8);
        send_bits({2'($urandom), a}, 8);
        for (int i = 0; i < n; i++) send_bits(wbuf[i], 8);
        end_txn();
    endtask

    // miso monitor: assemble a byte per 8 sclk rises; partial bytes are dropped at ss rise.
    initial begin
        logic [7:0] sh;
        int nb;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(posedge sclk or posedge ss);
            if (ss) begin
                nb = 0;
            end else begin
                sh = {sh[6:0], miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL miso_unexpected: got 0x%0h, no byte required", sh);
                    end else begin
                        check("miso_byte", 32'(sh), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // Write-strobe monitor: each single-cycle pulse must match the next predicted write.
    initial begin
        logic [13:0] e;
        forever begin
            @(negedge clock);
            if (wr_strobe) begin
                if (exp_wr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, none required", wr_addr, wr_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_strobe", 32'({wr_addr, wr_data}), 32'(e));
                end
            end
        end
    end

    initial begin
        int n;
        logic [5:0] a;
        for (int k = 0; k < 64; k++) mem[k] = 8'h00;

        repeat (3) @(negedge clock);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_cmd_error", 32'(cmd_error), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        do_read(6'h00, 3, -1, 12'h000);

        ax = 12'hF85; ay = 12'h07F; az = 12'h800;
        do_read(6'h0E, 6, -1, 12'h000);
        do_read(6'h08, 3, -1, 12'h000);

        ax = 12'h123;
        do_read(6'h0E, 2, 0, 12'h456);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        do_write(6'h2E, 2);
        do_read(6'h2E, 1, -1, 12'h000);
        do_read(6'h3F, 2, -1, 12'h000);

        check("cmd_error_clean", 32'(cmd_error), 32'd0);
        begin_txn();
        repeat (3) exp_q.push_back(8'h00);
        send_bits(8'h07, 8);
        send_bits(8'h20, 8);
        send_bits(8'h55, 8);
        end_txn();
        check("cmd_error_set", 32'(cmd_error), 32'd1);
        do_read(6'h01, 1, -1, 12'h000);
        check("cmd_error_sticky", 32'(cmd_error), 32'd1);

        wbuf[0] = 8'h3C;
        do_write(6'h20, 1);
        begin_txn();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        send_bits(8'h0A, 8);
        send_bits(8'h20, 8);
        send_bits(8'hFF, 5);
        end_txn();
        do_read(6'h20, 1, -1, 12'h000);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        do_write(6'h20, 4);
        wbuf[0] = 8'h51;
        do_write(6'h1F, 1);
        do_read(6'h1F, 3, -1, 12'h000);
        wbuf[0] = 8'h52;
        do_write(6'h1F, 1);
        do_read(6'h1F, 4, -1, 12'h000);

        repeat (30) begin
            ax = 12'($urandom); ay = 12'($urandom); az = 12'($urandom);
            a = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(28, 50));
            if ($urandom_range(0, 1) == 0) begin
                do_read(a, int'($urandom_range(1, 4)), -1, 12'h000);
            end else begin
                n = int'($urandom_range(1, 3));
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(a, n);
            end
        end

        wbuf[0] = 8'h9E;
        do_write(6'h21, 1);
        begin_txn();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hAD);
        send_bits(8'h0B, 8);
        send_bits(8'h00, 8);
        send_bits(8'($urandom), 8);
        send_bits(8'($urandom), 4);
        repeat (4) @(negedge clock);
        check("miso_before_reset", 32'(miso), 32'd1);
        reset = 1'b0;
        for (int k = 32; k <= 46; k++) mem[k] = 8'h00;
        #1;
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cmd_error", 32'(cmd_error), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        check("ignored_after_reset", 32'(busy), 32'd0);
        end_txn();
        do_read(6'h00, 2, -1, 12'h000);
        do_read(6'h20, 2, -1, 12'h000);

        repeat (20) @(negedge clock);
        check("miso_queue_drained", 32'(exp_q.size()), 32'd0);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_accel_responder.md
Name: spi_accel_responder

Overview:
- SPI-slave model of the ADXL362-style accelerometer, i.e. the responder end of the on-board accelerometer SPI link.
- It answers register read/write transactions from the SPI master on sclk/mosi/ss with miso.
- Register data comes from programmable X/Y/Z sample inputs.
- Used as a simulation stand-in and as a loopback target on the FPGA, so the accelerometer master and the tilt thresholds can be exercised without the physical sensor.

Parameters:
- DEVID_AD, 8'hAD, value of register 0x00.
- DEVID_MST, 8'h1D, value of register 0x01.
- PARTID, 8'hF2, value of register 0x02.
- SYNC_STAGES, 2, synchronizer depth on sclk/mosi/ss (minimum 2).

Ports:
- clock  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
- mosi  in  1  master-out data.
- ss  in  1  active-low slave select.
- miso  out  1  slave-out data.
- accel_x_in  in  12  signed X sample, two's complement.
- accel_y_in  in  12  signed Y sample.
- accel_z_in  in  12  signed Z sample.
- busy  out  1  high while a transaction is in progress.
- wr_strobe  out  1  one-cycle pulse per accepted register write.
- wr_addr  out  6  address of that write.
- wr_data  out  8  data of that write.
- cmd_error  out  1  sticky flag: unknown command byte seen; cleared by reset only.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, miso=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, cmd_error=0, writable registers=0.
- Input sync: sclk, mosi and ss each pass through SYNC_STAGES flops; edges are detected in the clock domain. Supported SCLK is at most clock/8 (12.5 MHz at 100 MHz); faster SCLK is unsupported.
- Bit order: MSB first. MOSI is sampled on synced sclk rising edges; miso changes on synced sclk falling edges.
- Bit counter: 3 bits; a byte completes on the 8th rising edge.
- Snapshot: on the ss falling edge, X/Y/Z are captured into shadow registers, so one transaction always reads a coherent sample.
- Register map (6-bit address; 0x00–0x3F accessible):
  - 0x00/0x01/0x02: DEVID_AD / DEVID_MST / PARTID (read-only).
  - 0x08/0x09/0x0A: X/Y/Z bits [11:4].
  - 0x0E/0x0F: XDATA_L = x[7:0]; XDATA_H = {4 copies of x[11], x[11:8]}.
  - 0x10/0x11: YDATA_L / YDATA_H, same packing as X.
  - 0x12/0x13: ZDATA_L / ZDATA_H, same packing as X.
  - 0x1F–0x2E: writable RAM.
  - All other addresses read 0x00; writes to them are ignored, with no wr_strobe.
- Soft reset: writing 0x52 to 0x1F clears 0x20–0x2E on the following cycle. 0x1F itself always reads 0x00.
- FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE.
  - IDLE -> CMD on ss falling edge; busy=1.
  - CMD byte complete:
    - 0x0B -> ADDR (read).
    - 0x0A -> ADDR (write).
    - anything else -> IGNORE and set cmd_error.
  - ADDR byte complete: latch addr = byte[5:0] (bits 7:6 ignored), then go to RD_DATA or WR_DATA.
  - RD_DATA: at the last rising edge of the previous byte, tx_shift loads reg[addr] and addr increments. The MSB drives miso at the next falling edge; remaining bits follow on subsequent falling edges.
  - WR_DATA: on each completed byte, write reg[addr] (if writable), pulse wr_strobe with wr_addr/wr_data for exactly one clock, then increment addr.
  - IGNORE: consume bits, no side effects.
  - Any state -> IDLE on ss rising edge, within SYNC_STAGES+1 clocks. busy=0, miso=0, bit counter cleared; a partial byte is discarded (no write).
- Address auto-increment wraps 0x3F -> 0x00.
- miso is 0 whenever synced ss is high, and during CMD/ADDR/WR_DATA.
- If ss rises and falls again, a new transaction starts cleanly.
- Simultaneous ss rising edge and sclk edge in the same clock: ss wins and the edge is ignored.
- If reset asserts mid-transaction, everything returns to reset values immediately. After reset releases, the first transaction begins only at a fresh ss falling edge; a transaction already in progress (ss already low) is ignored.

Decomposition:
- Shared package spi_accel_pkg: command constants (CMD_WRITE=8'h0A, CMD_READ=8'h0B), register address localparams, SOFT_RESET_KEY=8'h52, FSM state encoding.
- One sub-module, spi_edge_sync: synchronizer plus rising/falling edge detect. It is instantiated for sclk and ss; mosi uses the data path only.

Test Plan:
- Read ID: ss low; send 0x0B, 0x00, then 3 dummy bytes -> miso bytes 0xAD, 0x1D, 0xF2; busy=1 throughout; busy=0 within 3 clocks of ss high.
- Burst read of sign-extended data: accel_x_in=12'hF85, accel_y_in=12'h07F, accel_z_in=12'h800; read 0x0E for 6 bytes -> 0x85, 0xFF, 0x7F, 0x00, 0x00, 0xF8.
- Snapshot coherence: change accel_x_in from 12'h123 to 12'h456 between the XDATA_L and XDATA_H bytes -> reads 0x23, 0x01.
- Write and read-back with wrap: write 0x0A, 0x2E, 0xA5, 0x5A -> wr_strobe pulses at (0x2E, 0xA5) and (0x2F, suppressed); read 0x2E -> 0xA5. Read at 0x3F for 2 bytes -> 0x00, 0xAD (wraps to 0x00).
- Bad command and abort: send 0x07 -> cmd_error=1, miso=0, no writes. Write 0x0A, 0x20 plus 5 data bits, then ss high -> no wr_strobe; reg 0x20 unchanged.
- Soft reset and async reset: write 0x52 to 0x1F -> 0x20 reads 0x00. Assert reset mid-read -> miso=0, busy=0 immediately; the next full transaction reads correctly.
